timing_violation_logger: RTL and testbench

- Consumer end of the timing-check notifier interface. Each `$setup`/`$hold` check in a cell model toggles its notifier reg on a violation; this block observes those notifier lines as asynchronous inputs.
- Converts every notifier change into a timestamped event and queues it in a small FIFO.
- Exposes the events to a bench or debug reader over a valid/ready interface.
- Keeps a saturating violation count and a sticky overflow flag.
- Sits next to annotated gate-level DUTs in SDF timing-check benches.

---
 rtl/timing_violation_logger_if.sv | 40 ++++
 rtl/timing_violation_logger.sv | 185 ++++++++++++++++++
 tb/tb_timing_violation_logger.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timing_violation_logger_if.sv
// -----------------------------------------------------------------------------
// timing_violation_logger_if
//
// Purpose:
//    Valid/ready event bus between the timing violation logger and whatever
//    reads its events (a bench or a debug reader).
//
// Signals:
//    evt_valid  event present at the head of the logger FIFO
//    evt_ready  reader accepts the head event
//    evt_time   timestamp of the head event
//    evt_mask   notifier sources that changed in that event's detect cycle
//
// Modports:
//    master  the logger side (drives valid/time/mask, samples ready)
//    slave   the reader side (samples valid/time/mask, drives ready)
// -----------------------------------------------------------------------------
interface timing_violation_logger_if #(
   parameter int NUM_SRC = 4,
   parameter int TS_W    = 16
);
   logic               evt_valid;
   logic               evt_ready;
   logic [TS_W-1:0]    evt_time;
   logic [NUM_SRC-1:0] evt_mask;

   modport master (
      output evt_valid,
      output evt_time,
      output evt_mask,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_time,
      input  evt_mask,
      output evt_ready
   );
endinterface

// File: rtl/timing_violation_logger.sv
// -----------------------------------------------------------------------------
// timing_violation_logger
//
// Purpose:
//    Watches the notifier regs toggled by $setup/$hold checks in annotated
//    gate-level cell models. Every change on a notifier line becomes a
//    timestamped event in a small show-ahead FIFO that a reader drains over a
//    valid/ready bus. A saturating count of detect cycles and a sticky
//    overflow flag summarise the run.
//
// Ports:
//    clk         sampling clock, all state updates on the rising edge
//    rst_n       asynchronous active-low reset
//    notifier_i  asynchronous notifier lines, any level change is a violation
//    clr_i       synchronous clear of counter, overflow, timestamp and FIFO
//    evt         event bus (master modport): evt_valid/evt_ready/evt_time/evt_mask
//    evt_count   number of detect cycles seen, saturating
//    overflow    sticky, at least one event was dropped on a full FIFO
// -----------------------------------------------------------------------------
module timing_violation_logger #(
   parameter int NUM_SRC = 4,
   parameter int TS_W    = 16,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_SRC-1:0]         notifier_i,
   input  logic                       clr_i,
   timing_violation_logger_if.master  evt,
   output logic [CNT_W-1:0]           evt_count,
   output logic                       overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      ARM_IDLE = 2'd0,
      ARM_ONE  = 2'd1,
      ARM_TWO  = 2'd2,
      ARMED    = 2'd3
   } armState_t;

   armState_t          armState;
   armState_t          armNext;

   logic [NUM_SRC-1:0] syncS1;
   logic [NUM_SRC-1:0] syncS2;
   logic [NUM_SRC-1:0] prevVal;
   logic [NUM_SRC-1:0] det;
   logic               anyDet;

   logic [TS_W-1:0]    timeStamp;

   logic [AW:0]        wrPtr;
   logic [AW:0]        rdPtr;
   logic [TS_W-1:0]    memTime [DEPTH];
   logic [NUM_SRC-1:0] memMask [DEPTH];
   logic               fifoEmpty;
   logic               fifoFull;
   logic               push;
   logic               pop;
   logic               drop;

   // Arming sequencer state register. After reset release the logger sits
   // out a few cycles so the synchronizers can fill with the real line
   // levels; clr_i deliberately does not restart this.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armState <= ARM_IDLE;
      end else begin
         armState <= armNext;
      end
   end

   // Arming next-state logic: step through the warm-up states once, then
   // stay armed until the next reset.
   always_comb begin
      armNext = armState;
      case (armState)
         ARM_IDLE: armNext = ARM_ONE;
         ARM_ONE:  armNext = ARM_TWO;
         ARM_TWO:  armNext = ARMED;
         ARMED:    armNext = ARMED;
         default:  armNext = ARM_IDLE;
      endcase
   end

   // Two-flop synchronizer per notifier line, followed by the previous-value
   // register used for edge detection. These keep tracking through clr_i so
   // that a clear never manufactures a fake edge afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         syncS1  <= '0;
         syncS2  <= '0;
         prevVal <= '0;
      end else begin
         syncS1  <= notifier_i;
         syncS2  <= syncS1;
         prevVal <= syncS2;
      end
   end

   // Edge detect and FIFO control. A detect while unarmed is suppressed,
   // which hides lines that were already high when reset was released.
   // A full FIFO still accepts a push when the head is popped in the same
   // cycle; only a push with no room and no pop is dropped.
   always_comb begin
      det       = (armState == ARMED) ? (syncS2 ^ prevVal) : '0;
      anyDet    = |det;
      fifoEmpty = (wrPtr == rdPtr);
      fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
      pop       = !fifoEmpty && evt.evt_ready && !clr_i;
      push      = anyDet && !clr_i && (!fifoFull || pop);
      drop      = anyDet && !clr_i && fifoFull && !pop;
   end

   // Free-running timestamp, wraps silently; clr_i restarts it from zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeStamp <= '0;
      end else if (clr_i) begin
         timeStamp <= '0;
      end else begin
         timeStamp <= timeStamp + TS_W'(1);
      end
   end

   // FIFO pointers carry one extra wrap bit so full and empty can be told
   // apart when the index bits match. A clear flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (clr_i) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + (AW+1)'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + (AW+1)'(1);
         end
      end
   end

   // FIFO storage. Contents need no reset because the outputs are masked
   // whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         memTime[wrPtr[AW-1:0]] <= timeStamp;
         memMask[wrPtr[AW-1:0]] <= det;
      end
   end

   // Violation counter and sticky overflow. Every detect cycle counts even
   // when its event is dropped; the counter holds at all-ones. A detect in
   // a clear cycle is discarded and not counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_count <= '0;
         overflow  <= 1'b0;
      end else if (clr_i) begin
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (anyDet && (evt_count != {CNT_W{1'b1}})) begin
            evt_count <= evt_count + CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Show-ahead read port: the head entry is presented directly, and reads
   // as zero while there is nothing queued.
   always_comb begin
      evt.evt_valid = !fifoEmpty;
      evt.evt_time  = fifoEmpty ? '0 : memTime[rdPtr[AW-1:0]];
      evt.evt_mask  = fifoEmpty ? '0 : memMask[rdPtr[AW-1:0]];
   end

endmodule

// File: tb/tb_timing_violation_logger.sv
// -----------------------------------------------------------------------------
// tb_timing_violation_logger
//
// Purpose:
//    Self-checking bench for timing_violation_logger. Instance A uses the
//    default widths; instance B uses a 4-bit timestamp and 2-bit counter to
//    reach wrap and saturation quickly. Expected events are pushed onto a
//    scoreboard queue when a notifier is toggled and popped when the reader
//    takes them from the DUT.
// -----------------------------------------------------------------------------
module tb_timing_violation_logger;

   typedef struct packed {
      logic [15:0] t;
      logic [3:0]  m;
   } expA_t;

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] m;
   } expB_t;

   typedef struct {
      logic [3:0] toggle;
      logic [7:0] expCount;
      logic       expOverflow;
      bit         keep;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] notifierA;
   logic [3:0] notifierB;
   logic       clrA;
   logic       clrB;
   logic [7:0] countA;
   logic       overflowA;
   logic [1:0] countB;
   logic       overflowB;

   expA_t      sbA[$];
   expB_t      sbB[$];
   vec_t       ovTable[10];

   int         assertCount = 0;
   int         failCount   = 0;
   int         cyc;

   timing_violation_logger_if #(.NUM_SRC(4), .TS_W(16)) busA();
   timing_violation_logger_if #(.NUM_SRC(4), .TS_W(4))  busB();

   timing_violation_logger #(.NUM_SRC(4), .TS_W(16), .DEPTH(8), .CNT_W(8)) dutA (
      .clk        (clk),
      .rst_n      (rst_n),
      .notifier_i (notifierA),
      .clr_i      (clrA),
      .evt        (busA),
      .evt_count  (countA),
      .overflow   (overflowA)
   );

   timing_violation_logger #(.NUM_SRC(4), .TS_W(4), .DEPTH(8), .CNT_W(2)) dutB (
      .clk        (clk),
      .rst_n      (rst_n),
      .notifier_i (notifierB),
      .clr_i      (clrB),
      .evt        (busB),
      .evt_count  (countB),
      .overflow   (overflowB)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Reference cycle count: number of rising edges since reset release or
   // since the last clear. An event whose line changes just after edge c is
   // expected to carry timestamp c+2.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0;
      end else if (clrA) begin
         cyc <= 0;
      end else begin
         cyc <= cyc + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reader side of bus A: every accepted head event must match the oldest
   // outstanding expectation.
   always @(negedge clk) begin
      expA_t e;
      if (rst_n && busA.evt_valid && busA.evt_ready) begin
         if (sbA.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL popA.unexpected: got time 0x%0h mask 0x%0h, expected no event",
                     busA.evt_time, busA.evt_mask);
         end else begin
            e = sbA.pop_front();
            checkOutput("popA.time", busA.evt_time, e.t);
            checkOutput("popA.mask", busA.evt_mask, e.m);
         end
      end
   end

   // Reader side of bus B.
   always @(negedge clk) begin
      expB_t e;
      if (rst_n && busB.evt_valid && busB.evt_ready) begin
         if (sbB.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL popB.unexpected: got time 0x%0h mask 0x%0h, expected no event",
                     busB.evt_time, busB.evt_mask);
         end else begin
            e = sbB.pop_front();
            checkOutput("popB.time", busB.evt_time, e.t);
            checkOutput("popB.mask", busB.evt_mask, e.m);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until #1 after the edge that brings the reference count to n.
   task automatic waitCyc(input int n);
      int guard = 0;
      while (cyc < n && guard < 2000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 2000) begin
         assertCount++;
         failCount++;
         $display("[TB] FAIL waitCyc.timeout: got cyc %0d, expected %0d", cyc, n);
      end
   endtask

   task automatic resetDut(input logic [3:0] nInit);
      rst_n           = 1'b0;
      notifierA       = nInit;
      notifierB       = 4'b0000;
      clrA            = 1'b0;
      clrB            = 1'b0;
      busA.evt_ready  = 1'b0;
      busB.evt_ready  = 1'b0;
      sbA.delete();
      sbB.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Toggle notifier lines on instance A and record the event it should
   // produce (unless the event is expected to be dropped).
   task automatic applyStimulus(input logic [3:0] mask, input bit keep);
      notifierA = notifierA ^ mask;
      if (keep) begin
         sbA.push_back({16'(cyc + 2), mask});
      end
   endtask

   task automatic applyStimulusB(input logic [3:0] mask);
      notifierB = notifierB ^ mask;
      sbB.push_back({4'(cyc + 2), mask});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of test, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 10; i++) begin
         ovTable[i].toggle      = 4'(1 << (i % 4));
         ovTable[i].expCount    = 8'(i + 1);
         ovTable[i].expOverflow = (i >= 8);
         ovTable[i].keep        = (i < 8);
      end

      // Reset state.
      rst_n          = 1'b0;
      notifierA      = 4'b0000;
      notifierB      = 4'b0000;
      clrA           = 1'b0;
      clrB           = 1'b0;
      busA.evt_ready = 1'b0;
      busB.evt_ready = 1'b0;
      #12;
      checkOutput("reset.valid",    busA.evt_valid, 0);
      checkOutput("reset.time",     busA.evt_time, 0);
      checkOutput("reset.mask",     busA.evt_mask, 0);
      checkOutput("reset.count",    countA, 0);
      checkOutput("reset.overflow", overflowA, 0);

      // Basic event timing.
      $display("[TB] basic event timing");
      resetDut(4'b0000);
      waitCyc(9);
      applyStimulus(4'b0001, 1);
      waitCyc(11);
      checkOutput("basic.validEarly", busA.evt_valid, 0);
      waitCyc(12);
      checkOutput("basic.valid", busA.evt_valid, 1);
      checkOutput("basic.mask",  busA.evt_mask, 4'b0001);
      checkOutput("basic.time",  busA.evt_time, 11);
      checkOutput("basic.count", countA, 1);

      // Merged event and ordered drain.
      $display("[TB] merged event and ordered drain");
      resetDut(4'b0000);
      waitCyc(5);
      applyStimulus(4'b1010, 1);
      waitCyc(10);
      applyStimulus(4'b0100, 1);
      waitCyc(14);
      checkOutput("merge.count", countA, 2);
      busA.evt_ready = 1'b1;
      waitCyc(20);
      checkOutput("merge.drained", sbA.size(), 0);
      checkOutput("merge.validAfter", busA.evt_valid, 0);
      checkOutput("merge.countAfter", countA, 2);

      // Overflow: ten events into an eight-deep FIFO with no reader.
      $display("[TB] overflow");
      resetDut(4'b0000);
      for (int i = 0; i < 10; i++) begin
         waitCyc(5 + 4 * i);
         applyStimulus(ovTable[i].toggle, ovTable[i].keep);
         waitCyc(9 + 4 * i);
         checkOutput("ovf.count",    countA, ovTable[i].expCount);
         checkOutput("ovf.overflow", overflowA, ovTable[i].expOverflow);
         checkOutput("ovf.valid",    busA.evt_valid, 1);
      end
      busA.evt_ready = 1'b1;
      waitCyc(57);
      checkOutput("ovf.drained",       sbA.size(), 0);
      checkOutput("ovf.validAfter",    busA.evt_valid, 0);
      checkOutput("ovf.overflowStick", overflowA, 1);
      checkOutput("ovf.countAfter",    countA, 10);

      // Push and pop in the same cycle while full: nothing is dropped.
      $display("[TB] push and pop while full");
      resetDut(4'b0000);
      for (int i = 0; i < 8; i++) begin
         waitCyc(5 + 4 * i);
         applyStimulus(ovTable[i].toggle, 1);
         waitCyc(9 + 4 * i);
         checkOutput("full.count",    countA, ovTable[i].expCount);
         checkOutput("full.overflow", overflowA, 0);
      end
      applyStimulus(4'b0001, 1);
      waitCyc(39);
      busA.evt_ready = 1'b1;
      waitCyc(41);
      checkOutput("full.overflowAfterBoth", overflowA, 0);
      waitCyc(53);
      checkOutput("full.drained",    sbA.size(), 0);
      checkOutput("full.countAfter", countA, 9);
      checkOutput("full.validAfter", busA.evt_valid, 0);

      // Lines held high through reset must not create events.
      $display("[TB] arming");
      resetDut(4'b1111);
      waitCyc(20);
      checkOutput("arm.valid", busA.evt_valid, 0);
      checkOutput("arm.count", countA, 0);
      waitCyc(22);
      applyStimulus(4'b0001, 1);
      waitCyc(26);
      checkOutput("arm.validLater", busA.evt_valid, 1);
      checkOutput("arm.mask",       busA.evt_mask, 4'b0001);
      checkOutput("arm.count1",     countA, 1);
      busA.evt_ready = 1'b1;
      waitCyc(32);
      checkOutput("arm.drained",    sbA.size(), 0);
      checkOutput("arm.validAfter", busA.evt_valid, 0);

      // Clear coincident with a detect.
      $display("[TB] clear with coincident event");
      resetDut(4'b0000);
      waitCyc(5);
      applyStimulus(4'b0001, 1);
      waitCyc(9);
      applyStimulus(4'b0010, 1);
      waitCyc(13);
      applyStimulus(4'b0100, 1);
      waitCyc(17);
      checkOutput("clr.countBefore", countA, 3);
      checkOutput("clr.validBefore", busA.evt_valid, 1);
      applyStimulus(4'b1000, 0);
      waitCyc(19);
      clrA = 1'b1;
      sbA.delete();
      tick();
      clrA = 1'b0;
      checkOutput("clr.valid",    busA.evt_valid, 0);
      checkOutput("clr.count",    countA, 0);
      checkOutput("clr.overflow", overflowA, 0);
      waitCyc(3);
      applyStimulus(4'b0001, 1);
      waitCyc(7);
      checkOutput("clr.restartTime", busA.evt_time, 5);
      busA.evt_ready = 1'b1;
      waitCyc(14);
      checkOutput("clr.drained",    sbA.size(), 0);
      checkOutput("clr.countAfter", countA, 1);
      checkOutput("clr.validAfter", busA.evt_valid, 0);

      // Counter saturation and timestamp wrap on the narrow instance.
      $display("[TB] saturation and wrap");
      resetDut(4'b0000);
      busB.evt_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         waitCyc(5 + 4 * i);
         applyStimulusB(4'(1 << (i % 4)));
         waitCyc(9 + 4 * i);
         checkOutput("sat.count", countB, (i < 3) ? (i + 1) : 3);
      end
      waitCyc(30);
      checkOutput("sat.drained",  sbB.size(), 0);
      checkOutput("sat.overflow", overflowB, 0);

      // Asynchronous reset while events are queued.
      $display("[TB] async reset mid-operation");
      resetDut(4'b0000);
      waitCyc(5);
      applyStimulus(4'b0001, 1);
      waitCyc(9);
      applyStimulus(4'b0010, 1);
      waitCyc(14);
      checkOutput("arst.validBefore", busA.evt_valid, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst.validNow", busA.evt_valid, 0);
      checkOutput("arst.countNow", countA, 0);
      checkOutput("arst.timeNow",  busA.evt_time, 0);
      sbA.delete();
      @(negedge clk);
      rst_n = 1'b1;
      waitCyc(6);
      checkOutput("arst.validAfter", busA.evt_valid, 0);
      checkOutput("arst.countAfter", countA, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
